// File: rtl/wf68k30l_pkg.sv
// Shared types and constants for the WF68K30L MOVEP byte-lane sequencer.
// The ABORT state exists only when WF68K30L_MOVEP_BERR_EN is defined.
package wf68k30l_pkg;

`ifdef WF68K30L_MOVEP_BERR_EN
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REQ,
    ST_GAP,
    ST_FINISH,
    ST_ABORT
  } movep_st_e;
`else
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REQ,
    ST_GAP,
    ST_FINISH
  } movep_st_e;
`endif

  localparam int unsigned LONG_BYTES = 4;
  localparam int unsigned WORD_BYTES = 2;
  localparam int unsigned ADR_STRIDE = 2;

  // Byte lanes sit on every other address, MSB at the base.
  function automatic logic [31:0] lane_off(
    input logic       long_op,
    input logic [1:0] pntr
  );
    logic [1:0] last;
    logic [1:0] idx;
    last = long_op ? 2'(LONG_BYTES - 1) : 2'(WORD_BYTES - 1);
    idx  = last - pntr;
    return 32'(idx) * 32'(ADR_STRIDE);
  endfunction

  function automatic logic [7:0] byte_sel(
    input logic [31:0] d,
    input logic [1:0]  p
  );
    return d[{p, 3'b000} +: 8];
  endfunction

endpackage

// File: rtl/wf68k30l_movep_lanes.sv
// MOVEP byte-lane sequencer: one byte bus cycle per lane, MSB first.
// Define WF68K30L_MOVEP_BERR_EN to abort a transfer on BUS_ERR.
module wf68k30l_movep_lanes
  import wf68k30l_pkg::*;
(
  input  logic        CLK,
  input  logic        RESET_CPUn,
  input  logic        START,
  input  logic        REG_TO_MEM,
  input  logic        OP_LONG,
  input  logic [31:0] BASE_ADR,
  input  logic [31:0] REG_DATA,
  output logic        BUS_REQ,
  output logic [31:0] BUS_ADR,
  output logic        BUS_WR,
  output logic [7:0]  BUS_DOUT,
  input  logic [7:0]  BUS_DIN,
  input  logic        BUS_RDY,
  input  logic        BUS_ERR,
  output logic [1:0]  BYTE_PNTR,
  output logic        BUSY,
  output logic        DONE,
  output logic        RESULT_VALID,
  output logic [31:0] RESULT,
  output logic        ERR
);

  movep_st_e   st_q, st_d;
  logic [1:0]  ptr_q, ptr_d;
  logic [31:0] base_q, base_d;
  logic [31:0] data_q, data_d;
  logic        wr_q, wr_d;
  logic        long_q, long_d;
  logic [31:0] asm_q, asm_d;
  logic [31:0] result_q, result_d;
  logic        bus_req_q, bus_req_d;
  logic [31:0] bus_adr_q, bus_adr_d;
  logic        bus_wr_q, bus_wr_d;
  logic [7:0]  bus_dout_q, bus_dout_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        rv_q, rv_d;
  logic        err_q, err_d;

`ifndef WF68K30L_MOVEP_BERR_EN
  logic unused_berr;
  assign unused_berr = BUS_ERR;
`endif

  always_comb begin
    st_d     = st_q;
    ptr_d    = ptr_q;
    base_d   = base_q;
    data_d   = data_q;
    wr_d     = wr_q;
    long_d   = long_q;
    asm_d    = asm_q;
    result_d = result_q;
    unique case (st_q)
      ST_IDLE: begin
        if (START) begin
          base_d = BASE_ADR;
          data_d = REG_DATA;
          wr_d   = REG_TO_MEM;
          long_d = OP_LONG;
          ptr_d  = OP_LONG ? 2'd3 : 2'd1;
          asm_d  = '0;
          st_d   = ST_REQ;
        end
      end
      ST_REQ: begin
`ifdef WF68K30L_MOVEP_BERR_EN
        if (BUS_ERR) begin
          st_d = ST_ABORT;
        end else
`endif
        if (BUS_RDY) begin
          if (!wr_q) begin
            asm_d[{ptr_q, 3'b000} +: 8] = BUS_DIN;
          end
          if (ptr_q == 2'd0) begin
            st_d = ST_FINISH;
            if (!wr_q) begin
              result_d = long_q ? asm_d
                                : {data_q[31:16], asm_d[15:0]};
            end
          end else begin
            ptr_d = ptr_q - 2'd1;
            st_d  = ST_GAP;
          end
        end
      end
      ST_GAP:    st_d = ST_REQ;
      ST_FINISH: st_d = ST_IDLE;
`ifdef WF68K30L_MOVEP_BERR_EN
      ST_ABORT:  st_d = ST_IDLE;
`endif
      default:   st_d = ST_IDLE;
    endcase
  end

  // Bus outputs follow the next state so they are registered and steady.
  always_comb begin
    bus_req_d  = (st_d == ST_REQ);
    bus_adr_d  = bus_req_d ? base_d + lane_off(long_d, ptr_d) : '0;
    bus_wr_d   = bus_req_d & wr_d;
    bus_dout_d = bus_wr_d ? byte_sel(data_d, ptr_d) : '0;
    busy_d     = (st_d == ST_REQ) || (st_d == ST_GAP);
    done_d     = (st_d == ST_FINISH);
    rv_d       = done_d & ~wr_d;
`ifdef WF68K30L_MOVEP_BERR_EN
    err_d      = (st_d == ST_ABORT);
`else
    err_d      = 1'b0;
`endif
  end

  always_ff @(posedge CLK) begin
    if (!RESET_CPUn) begin
      st_q       <= ST_IDLE;
      ptr_q      <= '0;
      base_q     <= '0;
      data_q     <= '0;
      wr_q       <= 1'b0;
      long_q     <= 1'b0;
      asm_q      <= '0;
      result_q   <= '0;
      bus_req_q  <= 1'b0;
      bus_adr_q  <= '0;
      bus_wr_q   <= 1'b0;
      bus_dout_q <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      rv_q       <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      st_q       <= st_d;
      ptr_q      <= ptr_d;
      base_q     <= base_d;
      data_q     <= data_d;
      wr_q       <= wr_d;
      long_q     <= long_d;
      asm_q      <= asm_d;
      result_q   <= result_d;
      bus_req_q  <= bus_req_d;
      bus_adr_q  <= bus_adr_d;
      bus_wr_q   <= bus_wr_d;
      bus_dout_q <= bus_dout_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      rv_q       <= rv_d;
      err_q      <= err_d;
    end
  end

  assign BUS_REQ      = bus_req_q;
  assign BUS_ADR      = bus_adr_q;
  assign BUS_WR       = bus_wr_q;
  assign BUS_DOUT     = bus_dout_q;
  assign BYTE_PNTR    = ptr_q;
  assign BUSY         = busy_q;
  assign DONE         = done_q;
  assign RESULT_VALID = rv_q;
  assign RESULT       = result_q;
  assign ERR          = err_q;

endmodule

// File: tb/tb_wf68k30l_movep_lanes.sv
// Directed bench for the MOVEP byte-lane sequencer.
// Same expectations file covers both WF68K30L_MOVEP_BERR_EN builds.
module tb_wf68k30l_movep_lanes;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic        reg_to_mem;
  logic        op_long;
  logic [31:0] base_adr;
  logic [31:0] reg_data;
  logic        bus_req;
  logic [31:0] bus_adr;
  logic        bus_wr;
  logic [7:0]  bus_dout;
  logic [7:0]  bus_din;
  logic        bus_rdy;
  logic        bus_err;
  logic [1:0]  byte_pntr;
  logic        busy;
  logic        done;
  logic        result_valid;
  logic [31:0] result;
  logic        err;

  int checks = 0;
  int failures = 0;

  logic [31:0] adr_log [4];
  logic [7:0]  dout_log [4];
  logic        wr_log [4];
  int          nlog;
  int          done_cnt, rv_cnt, err_cnt, gap_bad;
  logic        busy_first;
  logic [1:0]  pntr_first;
  logic [31:0] res_at_done;

  always #5 clk = ~clk;

  wf68k30l_movep_lanes dut (
    .CLK          (clk),
    .RESET_CPUn   (rst_n),
    .START        (start),
    .REG_TO_MEM   (reg_to_mem),
    .OP_LONG      (op_long),
    .BASE_ADR     (base_adr),
    .REG_DATA     (reg_data),
    .BUS_REQ      (bus_req),
    .BUS_ADR      (bus_adr),
    .BUS_WR       (bus_wr),
    .BUS_DOUT     (bus_dout),
    .BUS_DIN      (bus_din),
    .BUS_RDY      (bus_rdy),
    .BUS_ERR      (bus_err),
    .BYTE_PNTR    (byte_pntr),
    .BUSY         (busy),
    .DONE         (done),
    .RESULT_VALID (result_valid),
    .RESULT       (result),
    .ERR          (err)
  );

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Runs one MOVEP; bus answers after `waits` idle REQ cycles.
  // din supplies read bytes in bus order, first byte in [31:24].
  task automatic xfer(input logic wr, input logic lng,
                      input logic [31:0] base, input logic [31:0] data,
                      input logic [31:0] din, input int waits,
                      input int err_idx, input bit poke);
    int  w;
    bit  fin;
    nlog = 0; done_cnt = 0; rv_cnt = 0; err_cnt = 0; gap_bad = 0;
    w = 0; fin = 0; res_at_done = '0;
    start = 1; reg_to_mem = wr; op_long = lng;
    base_adr = base; reg_data = data;
    tick();
    start = 0;
    busy_first = busy;
    pntr_first = byte_pntr;
    for (int c = 0; c < 60 && !fin; c++) begin
      if (poke && c == 1) begin
        start = 1; reg_to_mem = ~wr; op_long = ~lng;
        base_adr = 32'hDEAD0000; reg_data = 32'hFFFFFFFF;
      end
      if (bus_req) begin
        if (w == waits) begin
          bus_rdy = 1;
          bus_din = din[31 - 8*nlog -: 8];
          if (nlog == err_idx) bus_err = 1;
          if (nlog < 4) begin
            adr_log[nlog]  = bus_adr;
            dout_log[nlog] = bus_dout;
            wr_log[nlog]   = bus_wr;
          end
          nlog++;
          w = 0;
        end else begin
          w++;
        end
      end
      tick();
      start = 0;
      if (bus_rdy && !done && !err && bus_req) gap_bad++;
      bus_rdy = 0; bus_err = 0;
      if (done) begin done_cnt++; res_at_done = result; end
      if (result_valid) rv_cnt++;
      if (err) err_cnt++;
      if (done || err) fin = 1;
    end
    if (!fin) chk("xfer_timeout", 32'd0, 32'd1);
    tick();
    if (done) done_cnt++;
    if (result_valid) rv_cnt++;
    if (err) err_cnt++;
    chk("post_busy", {31'd0, busy}, 32'd0);
  endtask

  initial begin
    rst_n = 0; start = 1; reg_to_mem = 1; op_long = 1;
    base_adr = 32'h40; reg_data = 32'h1;
    bus_din = 0; bus_rdy = 0; bus_err = 0;
    tick();
    tick();
    start = 0;
    rst_n = 1;
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_req", {31'd0, bus_req}, 32'd0);
    chk("rst_adr", bus_adr, 32'd0);
    chk("rst_pntr", {30'd0, byte_pntr}, 32'd0);
    chk("rst_result", result, 32'd0);
    chk("rst_flags", {29'd0, done, result_valid, err}, 32'd0);
    tick();
    chk("rst_start_drop", {30'd0, busy, bus_req}, 32'd0);

    // Long write, one wait state per byte.
    xfer(1, 1, 32'h1000, 32'hAABBCCDD, 32'h0, 1, -1, 0);
    chk("wl_busy", {31'd0, busy_first}, 32'd1);
    chk("wl_pntr", {30'd0, pntr_first}, 32'd3);
    chk("wl_n", nlog, 4);
    for (int i = 0; i < 4; i++) begin
      chk("wl_adr", adr_log[i], 32'h1000 + 32'(2*i));
      chk("wl_wr", {31'd0, wr_log[i]}, 32'd1);
    end
    chk("wl_dout", {dout_log[0], dout_log[1], dout_log[2], dout_log[3]},
        32'hAABBCCDD);
    chk("wl_gap", gap_bad, 0);
    chk("wl_done", done_cnt, 1);
    chk("wl_rv", rv_cnt, 0);

    // Word read keeps upper Dn half.
    xfer(0, 0, 32'h2000, 32'h12345678, 32'h9ABC0000, 0, -1, 0);
    chk("rw_pntr", {30'd0, pntr_first}, 32'd1);
    chk("rw_adr0", adr_log[0], 32'h2000);
    chk("rw_adr1", adr_log[1], 32'h2002);
    chk("rw_wr", {31'd0, wr_log[0] | wr_log[1]}, 32'd0);
    chk("rw_dout", {24'd0, dout_log[0]}, 32'd0);
    chk("rw_res_done", res_at_done, 32'h12349ABC);
    chk("rw_rv", rv_cnt, 1);
    chk("rw_done", done_cnt, 1);
    chk("rw_hold", result, 32'h12349ABC);

    // Long read with address wrap.
    xfer(0, 1, 32'hFFFFFFFE, 32'h0, 32'h01020304, 1, -1, 0);
    chk("wr_adr0", adr_log[0], 32'hFFFFFFFE);
    chk("wr_adr1", adr_log[1], 32'h00000000);
    chk("wr_adr2", adr_log[2], 32'h00000002);
    chk("wr_adr3", adr_log[3], 32'h00000004);
    chk("wr_res", result, 32'h01020304);
    chk("wr_rv", rv_cnt, 1);

    // Reset during the second REQ.
    start = 1; reg_to_mem = 1; op_long = 1;
    base_adr = 32'h5000; reg_data = 32'hCAFEF00D;
    tick();
    start = 0;
    bus_rdy = 1;
    tick();
    bus_rdy = 0;
    tick();
    chk("mr_req2", {31'd0, bus_req}, 32'd1);
    chk("mr_adr2", bus_adr, 32'h5002);
    chk("mr_dout2", {24'd0, bus_dout}, 32'h000000FE);
    rst_n = 0;
    tick();
    rst_n = 1;
    chk("mr_clear", {29'd0, bus_req, busy, done}, 32'd0);
    chk("mr_res", result, 32'd0);
    tick();
    chk("mr_idle", {30'd0, busy, bus_req}, 32'd0);
    xfer(1, 0, 32'h6000, 32'h00003456, 32'h0, 0, -1, 0);
    chk("mr_after_adr", adr_log[1], 32'h6002);
    chk("mr_after_dout", {dout_log[0], dout_log[1]}, 32'h3456);
    chk("mr_after_done", done_cnt, 1);

    // Read word to load a known RESULT, then error on the second byte.
    xfer(0, 0, 32'h7000, 32'hA5A50000, 32'h11220000, 0, -1, 0);
    chk("be_pre", result, 32'hA5A51122);
    xfer(0, 1, 32'h8000, 32'h0, 32'h55667788, 0, 1, 0);
`ifdef WF68K30L_MOVEP_BERR_EN
    chk("be_err", err_cnt, 1);
    chk("be_done", done_cnt, 0);
    chk("be_rv", rv_cnt, 0);
    chk("be_res", result, 32'hA5A51122);
`else
    chk("be_err", err_cnt, 0);
    chk("be_done", done_cnt, 1);
    chk("be_rv", rv_cnt, 1);
    chk("be_res", result, 32'h55667788);
`endif

    // START while busy must not disturb latched operands.
    xfer(1, 1, 32'h3000, 32'h11223344, 32'h0, 1, -1, 1);
    chk("bp_n", nlog, 4);
    chk("bp_adr3", adr_log[3], 32'h3006);
    chk("bp_dout", {dout_log[0], dout_log[1], dout_log[2], dout_log[3]},
        32'h11223344);
    chk("bp_done", done_cnt, 1);
    tick();
    chk("bp_idle", {30'd0, busy, bus_req}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/wf68k30l_movep_lanes.md
WF68K30L_MOVEP_LANES -- requirements
Module: WF68K30L_MOVEP_LANES

Interface
REQ-001 CLK  in  1  single clock; all state updates on rising edge.
REQ-002 RESET_CPUn  in  1  synchronous, active-low reset.
REQ-003 START  in  1  one-cycle MOVEP launch pulse from control.
REQ-004 REG_TO_MEM  in  1  1 = Dn to memory, 0 = memory to Dn.
REQ-005 OP_LONG  in  1  1 = 4 bytes, 0 = 2 bytes.
REQ-006 BASE_ADR  in  32  effective address (d16,An), sampled at START.
REQ-007 REG_DATA  in  32  Dn contents, sampled at START.
REQ-008 BUS_REQ / BUS_ADR / BUS_WR / BUS_DOUT  out  1/32/1/8  byte bus cycle request, address, write strobe, write byte.
REQ-009 BUS_DIN  in  8  read byte; BUS_RDY  in  1  cycle termination; BUS_ERR  in  1  bus error.
REQ-010 BYTE_PNTR  out  2  remaining-byte index, downcounting.
REQ-011 BUSY  out  1; DONE  out  1; RESULT_VALID  out  1; RESULT  out  32; ERR  out  1.

Function
REQ-012 FSM states: IDLE, REQ, GAP, FINISH, ABORT.
REQ-013 IDLE: START latches BASE_ADR, REG_DATA, REG_TO_MEM, OP_LONG; BYTE_PNTR <= 3 (long) or 1 (word); go to REQ; BUSY=1 from the next cycle.
REQ-014 START outside IDLE is ignored.
REQ-015 REQ: BUS_REQ=1; BUS_ADR = latched base + 2*(N-1-BYTE_PNTR), N = 4 or 2, modulo 2^32, no fault on wrap.
REQ-016 REQ, write: BUS_WR=1; BUS_DOUT = latched data byte BYTE_PNTR (bits 8*p+7:8*p), most significant byte first.
REQ-017 REQ, read: BUS_WR=0; on BUS_RDY, BUS_DIN goes into byte BYTE_PNTR of the assembly register.
REQ-018 BUS_RDY in REQ with BYTE_PNTR != 0: decrement BYTE_PNTR; go to GAP.
REQ-019 GAP lasts one cycle with BUS_REQ=0, then returns to REQ.
REQ-020 BUS_RDY in REQ with BYTE_PNTR == 0: go to FINISH.
REQ-021 FINISH lasts one cycle: DONE=1.
REQ-022 FINISH, read: RESULT_VALID=1.
REQ-023 FINISH, read, long: RESULT = all 4 assembled bytes.
REQ-024 FINISH, read, word: RESULT = {latched REG_DATA[31:16], assembled[15:0]}.
REQ-025 FINISH then goes to IDLE; BUSY=0 in FINISH.
REQ-026 RESULT holds its value until the next read completes; RESULT_VALID and DONE are single-cycle pulses.
REQ-027 BUS_ADR, BUS_WR, BUS_DOUT stay stable for the whole REQ residency; they are zero when BUS_REQ=0.
REQ-028 BUS_RDY outside REQ is ignored.
REQ-029 BUS_RDY and BUS_ERR in the same cycle: BUS_ERR wins (when enabled).

Reset
REQ-030 RESET_CPUn low at an edge forces IDLE from any state, mid-transfer included.
REQ-031 Reset values: BUS_REQ, BUS_WR, BUS_DOUT, BUS_ADR, BYTE_PNTR, BUSY, DONE, RESULT_VALID, ERR = 0; RESULT = 0.
REQ-032 A START coincident with reset is discarded.

Configuration
REQ-033 Macro WF68K30L_MOVEP_BERR_EN defined: BUS_ERR in REQ goes to ABORT.
REQ-034 ABORT lasts one cycle: ERR=1, DONE=0, RESULT_VALID=0, RESULT unchanged, then IDLE.
REQ-035 Macro WF68K30L_MOVEP_BERR_EN undefined: BUS_ERR is ignored, ABORT is absent, ERR is tied 0.

Structure
REQ-036 Shared package wf68k30L_pkg.svh holds the FSM state enum type, the LONG/WORD byte-count constants (4, 2) and the address stride constant (2).
REQ-037 The block is single-level; no sub-module.
REQ-038 Byte select and address offset are plain combinational logic inside the block.

Verification
REQ-039 Write long: START, REG_TO_MEM=1, OP_LONG=1, BASE=0x1000, REG_DATA=0xAABBCCDD, BUS_RDY after 1 wait -> writes 0x1000=AA, 0x1002=BB, 0x1004=CC, 0x1006=DD; one GAP cycle between writes; DONE pulse; RESULT_VALID=0.
REQ-040 Read word: REG_DATA=0x12345678, BASE=0x2000, BUS_DIN 0x9A then 0xBC -> RESULT=0x12349ABC, RESULT_VALID and DONE one cycle.
REQ-041 Wrap: BASE=0xFFFFFFFE, long read -> addresses FFFFFFFE, 00000000, 00000002, 00000004.
REQ-042 Reset mid-transfer: RESET_CPUn low during 2nd REQ -> next cycle BUS_REQ=0, BUSY=0, no DONE; a following START runs normally.
REQ-043 WF68K30L_MOVEP_BERR_EN defined, BUS_ERR with BUS_RDY on byte 2 -> ERR pulse, no DONE, RESULT unchanged. Undefined -> the same stimulus completes normally.
REQ-044 START while BUSY -> ignored; the latched operands are not disturbed.
